// File: rtl/mvm_result_serializer_if.sv
// Result-serializer bus: multiplier capture side, element stream side and status.
// master = the serializer, slave = whoever drives it and consumes the stream.
interface mvm_result_serializer_if #(
   parameter int NUM_ELEMS = 6,
   parameter int WIDTH     = 8
);
   localparam int IW = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;

   logic                       in_done;
   logic [NUM_ELEMS*WIDTH-1:0] in_vector;
   logic [WIDTH-1:0]           out_data;
   logic                       out_valid;
   logic                       out_ready;
   logic                       out_last;
   logic [IW-1:0]              out_index;
   logic                       busy;
   logic                       pending_full;
   logic                       overflow;
   logic                       clear_overflow;

   modport master (
      input  in_done, in_vector, out_ready, clear_overflow,
      output out_data, out_valid, out_last, out_index, busy, pending_full, overflow
   );

   modport slave (
      output in_done, in_vector, out_ready, clear_overflow,
      input  out_data, out_valid, out_last, out_index, busy, pending_full, overflow
   );
endinterface

// File: rtl/mvm_result_serializer.sv
// Captures MVM result vectors on done and streams them one element per beat,
// with one pending slot so a back-to-back result is absorbed without stalling.
module mvm_result_serializer #(
   parameter int NUM_ELEMS = 6,
   parameter int WIDTH     = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   mvm_result_serializer_if.master       bus
);
   localparam int IW = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;

   // Packed index NUM_ELEMS-1 is the MSB slice, i.e. element 0 of the vector.
   typedef logic [NUM_ELEMS-1:0][WIDTH-1:0] vec_t;
   typedef enum logic {IDLE, STREAM} state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] index_q, index_d;
   vec_t          active_q, active_d;
   vec_t          pending_q, pending_d;
   logic          pend_vld_q, pend_vld_d;
   logic          ovf_q, ovf_d;

   logic          streaming, at_last, fire;
   logic [WIDTH-1:0] data_sel;

   assign streaming = (state_q == STREAM);
   assign at_last   = (index_q == IW'(NUM_ELEMS - 1));
   assign fire      = streaming && bus.out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         index_q    <= '0;
         active_q   <= '0;
         pending_q  <= '0;
         pend_vld_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         index_q    <= index_d;
         active_q   <= active_d;
         pending_q  <= pending_d;
         pend_vld_q <= pend_vld_d;
         ovf_q      <= ovf_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      index_d    = index_q;
      active_d   = active_q;
      pending_d  = pending_q;
      pend_vld_d = pend_vld_q;
      ovf_d      = bus.clear_overflow ? 1'b0 : ovf_q;

      case (state_q)
         IDLE: begin
            if (bus.in_done) begin
               active_d = vec_t'(bus.in_vector);
               index_d  = '0;
               state_d  = STREAM;
            end
         end
         STREAM: begin
            if (fire && at_last) begin
               // Completing a vector frees a slot, so an arriving done is never dropped here.
               index_d = '0;
               if (pend_vld_q) begin
                  active_d = pending_q;
                  if (bus.in_done) pending_d  = vec_t'(bus.in_vector);
                  else             pend_vld_d = 1'b0;
               end else if (bus.in_done) begin
                  active_d = vec_t'(bus.in_vector);
               end else begin
                  state_d = IDLE;
               end
            end else begin
               if (fire) index_d = index_q + IW'(1);
               if (bus.in_done) begin
                  if (!pend_vld_q) begin
                     pending_d  = vec_t'(bus.in_vector);
                     pend_vld_d = 1'b1;
                  end else begin
                     ovf_d = 1'b1;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      data_sel = '0;
      for (int k = 0; k < NUM_ELEMS; k++)
         if (index_q == IW'(k)) data_sel = active_q[NUM_ELEMS-1-k];
   end

   assign bus.out_data     = data_sel;
   assign bus.out_valid    = streaming;
   assign bus.busy         = streaming;
   assign bus.out_last     = streaming && at_last;
   assign bus.out_index    = index_q;
   assign bus.pending_full = pend_vld_q;
   assign bus.overflow     = ovf_q;
endmodule
